// File: rtl/lane_traffic_source_if.sv
// Lane-count / emergency bus between the traffic source and the Breadboard controller.
// LANE_SOURCE_STATS_EN adds the departTotal statistics signal.
interface lane_traffic_source_if #(
  parameter int NUM_LANES = 8,
  parameter int COUNT_W   = 8
);
  logic [NUM_LANES-1:0]         arrive;
  logic [NUM_LANES-1:0]         emgArrive;
  logic [NUM_LANES-1:0]         lightIn;
  logic [NUM_LANES*COUNT_W-1:0] laneCount;
  logic                         emgSignal;
  logic [NUM_LANES-1:0]         emgLane;
  logic [NUM_LANES-1:0]         overflow;
`ifdef LANE_SOURCE_STATS_EN
  logic [15:0]                  departTotal;

  modport master (input arrive, emgArrive, lightIn,
                  output laneCount, emgSignal, emgLane, overflow, departTotal);
  modport slave  (output arrive, emgArrive, lightIn,
                  input laneCount, emgSignal, emgLane, overflow, departTotal);
`else
  modport master (input arrive, emgArrive, lightIn,
                  output laneCount, emgSignal, emgLane, overflow);
  modport slave  (output arrive, emgArrive, lightIn,
                  input laneCount, emgSignal, emgLane, overflow);
`endif
endinterface

// File: rtl/lane_traffic_source.sv
// Per-lane vehicle queue model driving lane counts and emergency requests into Breadboard.
// Optional macro LANE_SOURCE_STATS_EN adds the 16-bit departTotal counter.
module lane_traffic_source #(
  parameter int NUM_LANES       = 8,
  parameter int COUNT_W         = 8,
  parameter int DEPART_INTERVAL = 4
) (
  input logic                   clk,
  input logic                   rst,
  lane_traffic_source_if.master bus
);

  typedef enum logic [1:0] {IDLE, QUEUED, FLOW} laneState_t;

  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]         LAST_TICK = 4'(DEPART_INTERVAL - 1);

  laneState_t           state     [NUM_LANES];
  laneState_t           stateNext [NUM_LANES];
  logic [COUNT_W-1:0]   count     [NUM_LANES];
  logic [COUNT_W-1:0]   countNext [NUM_LANES];
  logic [3:0]           timer     [NUM_LANES];
  logic [3:0]           timerNext [NUM_LANES];
  logic [3:0]           effTimer  [NUM_LANES];

  logic [NUM_LANES-1:0] arrival;
  logic [NUM_LANES-1:0] flowing;
  logic [NUM_LANES-1:0] depart;
  logic [NUM_LANES-1:0] dropped;
  logic [NUM_LANES-1:0] pending;
  logic [NUM_LANES-1:0] pendingNext;
  logic [NUM_LANES-1:0] overflowR;
  logic                 emgSignalR;
  logic [NUM_LANES-1:0] emgLaneR;

  // Saturating update: arrival and departure together cancel, arrival at max is dropped.
  function automatic logic [COUNT_W-1:0] satCount(input logic [COUNT_W-1:0] c,
                                                  input logic add, input logic sub);
    case ({add, sub})
      2'b10:   return (c == CNT_MAX) ? c : c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

  always_comb begin
    arrival     = bus.arrive | bus.emgArrive;
    flowing     = '0;
    depart      = '0;
    dropped     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      // The first green cycle after QUEUED already counts toward the interval.
      effTimer[i]  = (state[i] == FLOW) ? timer[i] : 4'd0;
      flowing[i]   = (count[i] != '0) && bus.lightIn[i];
      depart[i]    = flowing[i] && (effTimer[i] == LAST_TICK);
      dropped[i]   = arrival[i] && (count[i] == CNT_MAX) && !depart[i];
      countNext[i] = satCount(count[i], arrival[i], depart[i]);
      timerNext[i] = flowing[i] ? (depart[i] ? 4'd0 : effTimer[i] + 4'd1) : 4'd0;
      if (countNext[i] == '0)
        stateNext[i] = IDLE;
      else if (flowing[i])
        stateNext[i] = FLOW;
      else
        stateNext[i] = QUEUED;
    end
    // A new emergency wins over a coincident departure.
    pendingNext = bus.emgArrive | (pending & ~depart);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state[i] <= IDLE;
        count[i] <= '0;
        timer[i] <= '0;
      end
      pending    <= '0;
      overflowR  <= '0;
      emgSignalR <= 1'b0;
      emgLaneR   <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state[i] <= stateNext[i];
        count[i] <= countNext[i];
        timer[i] <= timerNext[i];
      end
      pending    <= pendingNext;
      overflowR  <= overflowR | dropped;
      emgSignalR <= |pendingNext;
      emgLaneR   <= pendingNext & (~pendingNext + 1'b1);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : gPack
    assign bus.laneCount[g*COUNT_W +: COUNT_W] = count[g];
  end

  assign bus.emgSignal = emgSignalR;
  assign bus.emgLane   = emgLaneR;
  assign bus.overflow  = overflowR;

`ifdef LANE_SOURCE_STATS_EN
  logic [3:0]  departSum;
  logic [15:0] departTotalR;

  always_comb begin
    departSum = 4'd0;
    for (int i = 0; i < NUM_LANES; i++)
      departSum = departSum + {3'd0, depart[i]};
  end

  always_ff @(posedge clk) begin
    if (rst)
      departTotalR <= '0;
    else
      departTotalR <= departTotalR + {12'd0, departSum};
  end

  assign bus.departTotal = departTotalR;
`endif

endmodule

// File: tb/tb_lane_traffic_source.sv
// Directed bench for lane_traffic_source: vector table plus hand-written corner sequences.
module tb_lane_traffic_source;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nTests = 0;
  int   nFail  = 0;

  always #5 clk = ~clk;

  lane_traffic_source_if #(.NUM_LANES(8), .COUNT_W(8)) busIf ();

  lane_traffic_source #(.NUM_LANES(8), .COUNT_W(8), .DEPART_INTERVAL(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  typedef struct {
    logic [7:0]  arrive;
    logic [7:0]  emgArrive;
    logic [7:0]  lightIn;
    logic [63:0] expCount;
    logic        expSig;
    logic [7:0]  expLane;
    logic [7:0]  expOvf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] laneVal(input int lane, input int val);
    logic [63:0] v;
    v = 64'(val);
    return v << (8 * lane);
  endfunction

  function automatic vec_t mk(input logic [7:0] a, e, l, input logic [63:0] c,
                              input logic s, input logic [7:0] ln, o);
    vec_t v;
    v.arrive = a; v.emgArrive = e; v.lightIn = l;
    v.expCount = c; v.expSig = s; v.expLane = ln; v.expOvf = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] e, input logic [7:0] l);
    @(negedge clk);
    busIf.arrive    = a;
    busIf.emgArrive = e;
    busIf.lightIn   = l;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] laneOf(input int lane);
    return busIf.laneCount[8*lane +: 8];
  endfunction

  initial begin
    // Fill lane 3 to five vehicles with the light red.
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(8'h08, 8'h00, 8'h00, laneVal(3, k), 1'b0, 8'h00, 8'h00));
    // Hold green: one departure every fourth green cycle, then nothing once empty.
    for (int k = 1; k <= 22; k++)
      vecs.push_back(mk(8'h00, 8'h00, 8'h08, laneVal(3, (k >= 20) ? 0 : 5 - k / 4),
                        1'b0, 8'h00, 8'h00));
    // Emergencies on lanes 3 and 5; lowest index reported first.
    vecs.push_back(mk(8'h00, 8'h28, 8'h00, laneVal(3, 1) | laneVal(5, 1), 1'b1, 8'h08, 8'h00));
    for (int k = 1; k <= 3; k++)
      vecs.push_back(mk(8'h00, 8'h00, 8'h08, laneVal(3, 1) | laneVal(5, 1), 1'b1, 8'h08, 8'h00));
    vecs.push_back(mk(8'h00, 8'h00, 8'h08, laneVal(5, 1), 1'b1, 8'h20, 8'h00));
    for (int k = 1; k <= 3; k++)
      vecs.push_back(mk(8'h00, 8'h00, 8'h20, laneVal(5, 1), 1'b1, 8'h20, 8'h00));
    vecs.push_back(mk(8'h00, 8'h00, 8'h20, 64'd0, 1'b0, 8'h00, 8'h00));

    busIf.arrive = 8'hFF; busIf.emgArrive = 8'h00; busIf.lightIn = 8'h00;
    drive(8'hFF, 8'h00, 8'h00);
    drive(8'hFF, 8'h00, 8'h00);
    check("reset laneCount", busIf.laneCount, 64'd0);
    check("reset emgSignal", 64'(busIf.emgSignal), 64'd0);
    check("reset emgLane", 64'(busIf.emgLane), 64'd0);
    check("reset overflow", 64'(busIf.overflow), 64'd0);
    rst = 1'b0;

    foreach (vecs[n]) begin
      drive(vecs[n].arrive, vecs[n].emgArrive, vecs[n].lightIn);
      check($sformatf("vec%0d laneCount", n), busIf.laneCount, vecs[n].expCount);
      check($sformatf("vec%0d emgSignal", n), 64'(busIf.emgSignal), 64'(vecs[n].expSig));
      check($sformatf("vec%0d emgLane", n), 64'(busIf.emgLane), 64'(vecs[n].expLane));
      check($sformatf("vec%0d overflow", n), 64'(busIf.overflow), 64'(vecs[n].expOvf));
    end

    // Interrupted green on lane 1: the partial interval is discarded.
    for (int k = 0; k < 3; k++) drive(8'h02, 8'h00, 8'h00);
    check("lane1 filled", 64'(laneOf(1)), 64'd3);
    for (int k = 0; k < 3; k++) drive(8'h00, 8'h00, 8'h02);
    check("lane1 first green", 64'(laneOf(1)), 64'd3);
    drive(8'h00, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) drive(8'h00, 8'h00, 8'h02);
    check("lane1 3rd regreen", 64'(laneOf(1)), 64'd3);
    drive(8'h00, 8'h00, 8'h02);
    check("lane1 4th regreen", 64'(laneOf(1)), 64'd2);
    drive(8'h00, 8'h00, 8'h00);

    // Saturation on lane 7.
    for (int k = 0; k < 255; k++) drive(8'h80, 8'h00, 8'h00);
    check("lane7 at max", 64'(laneOf(7)), 64'd255);
    check("lane7 no ovf yet", 64'(busIf.overflow), 64'd0);
    drive(8'h80, 8'h00, 8'h00);
    check("lane7 held max", 64'(laneOf(7)), 64'd255);
    check("lane7 ovf set", 64'(busIf.overflow), 64'h80);
    for (int k = 0; k < 3; k++) drive(8'h00, 8'h00, 8'h80);
    check("lane7 green 3", 64'(laneOf(7)), 64'd255);
    drive(8'h00, 8'h00, 8'h80);
    check("lane7 depart from max", 64'(laneOf(7)), 64'd254);
    check("lane7 ovf sticky", 64'(busIf.overflow), 64'h80);

    // Arrival coinciding with a departure on lane 2.
    for (int k = 0; k < 4; k++) drive(8'h04, 8'h00, 8'h00);
    check("lane2 filled", 64'(laneOf(2)), 64'd4);
    for (int k = 0; k < 3; k++) drive(8'h00, 8'h00, 8'h04);
    drive(8'h04, 8'h00, 8'h04);
    check("lane2 arrive+depart", 64'(laneOf(2)), 64'd4);
    for (int k = 0; k < 3; k++) drive(8'h00, 8'h00, 8'h04);
    check("lane2 mid interval", 64'(laneOf(2)), 64'd4);
    drive(8'h00, 8'h00, 8'h04);
    check("lane2 next depart", 64'(laneOf(2)), 64'd3);

    // Emergency arriving on a departure edge stays pending until the next departure.
    for (int k = 0; k < 3; k++) drive(8'h00, 8'h00, 8'h04);
    drive(8'h00, 8'h04, 8'h04);
    check("lane2 emg+depart count", 64'(laneOf(2)), 64'd3);
    check("lane2 emg kept", 64'(busIf.emgSignal), 64'd1);
    check("lane2 emg lane", 64'(busIf.emgLane), 64'h04);
    for (int k = 0; k < 3; k++) drive(8'h00, 8'h00, 8'h04);
    check("lane2 emg still", 64'(busIf.emgSignal), 64'd1);
    drive(8'h00, 8'h00, 8'h04);
    check("lane2 emg cleared count", 64'(laneOf(2)), 64'd2);
    check("lane2 emg cleared", 64'(busIf.emgSignal), 64'd0);
    check("lane2 emgLane cleared", 64'(busIf.emgLane), 64'd0);
    check("ovf before rst", 64'(busIf.overflow), 64'h80);

    // Reset in the middle of a green interval.
    rst = 1'b1;
    drive(8'hFF, 8'hFF, 8'hFF);
    rst = 1'b0;
    check("midrst laneCount", busIf.laneCount, 64'd0);
    check("midrst emgSignal", 64'(busIf.emgSignal), 64'd0);
    check("midrst emgLane", 64'(busIf.emgLane), 64'd0);
    check("midrst overflow", 64'(busIf.overflow), 64'd0);
    drive(8'h00, 8'h00, 8'hFF);
    check("green on empty", busIf.laneCount, 64'd0);
    drive(8'h08, 8'h00, 8'hFF);
    check("arrive under green", busIf.laneCount, laneVal(3, 1));
    for (int k = 0; k < 3; k++) drive(8'h00, 8'h00, 8'hFF);
    check("fresh interval 3", busIf.laneCount, laneVal(3, 1));
    drive(8'h00, 8'h00, 8'hFF);
    check("fresh interval 4", busIf.laneCount, 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
